// File: rtl/miriscv_pkg.sv
// Shared LSU definitions: funct3 size codes, FSM state encoding and
// the byte-lane helpers used when a request is captured.
package miriscv_pkg;

  localparam logic [2:0] LDST_B  = 3'b000;
  localparam logic [2:0] LDST_H  = 3'b001;
  localparam logic [2:0] LDST_W  = 3'b010;
  localparam logic [2:0] LDST_BU = 3'b100;
  localparam logic [2:0] LDST_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } lsu_state_e;

  // Legal size for the direction and naturally aligned for that size.
  function automatic logic lsu_access_ok(input logic we, input logic [2:0] size,
                                         input logic [1:0] offset);
    logic ok;
    case (size)
      LDST_B:  ok = 1'b1;
      LDST_BU: ok = ~we;
      LDST_H:  ok = ~offset[0];
      LDST_HU: ok = ~we & ~offset[0];
      LDST_W:  ok = (offset == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] lsu_be(input logic [2:0] size, input logic [1:0] offset);
    logic [3:0] be;
    case (size[1:0])
      2'b00:   be = 4'b0001 << offset;
      2'b01:   be = 4'b0011 << offset;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lsu_wdata(input logic [2:0] size, input logic [31:0] d);
    logic [31:0] w;
    case (size[1:0])
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/miriscv_lsu_ldfmt.sv
// Load formatter: picks the addressed byte/halfword of the read word
// and sign- or zero-extends it according to funct3.
module miriscv_lsu_ldfmt
  import miriscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  size,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

    case (size)
      LDST_B:  data = {{24{byte_sel[7]}}, byte_sel};
      LDST_BU: data = {24'h0, byte_sel};
      LDST_H:  data = {{16{half_sel[15]}}, half_sel};
      LDST_HU: data = {16'h0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/miriscv_lsu.sv
// RV32 load/store unit: captures a core memory instruction, issues one
// word-aligned bus request and returns formatted load data.
module miriscv_lsu
  import miriscv_pkg::*;
(
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic [31:0] lsu_data_o,
  output logic        lsu_stall_req_o,
  output logic        lsu_err_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i
);

  lsu_state_e  state;
  logic [31:0] addr_q;
  logic [2:0]  size_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] load_q;

  logic        access_ok;
  logic        done;
  logic        in_req;
  logic [31:0] fmt_data;

  assign access_ok = lsu_access_ok(lsu_we_i, lsu_size_i, lsu_addr_i[1:0]);
  assign done      = (state == RESP) & data_rvalid_i;
  assign in_req    = (state == REQ);

  assign lsu_err_o       = (state == IDLE) & lsu_req_i & ~access_ok;
  assign lsu_stall_req_o = lsu_req_i & ~done & ~lsu_err_o;

  miriscv_lsu_ldfmt u_ldfmt (
    .rdata  (data_rdata_i),
    .offset (addr_q[1:0]),
    .size   (size_q),
    .data   (fmt_data)
  );

  // Lane formatting is done at capture so the bus sees only registered values.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state   <= IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      load_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (lsu_req_i && access_ok) begin
            addr_q  <= lsu_addr_i;
            size_q  <= lsu_size_i;
            we_q    <= lsu_we_i;
            be_q    <= lsu_be(lsu_size_i, lsu_addr_i[1:0]);
            wdata_q <= lsu_wdata(lsu_size_i, lsu_data_i);
            state   <= REQ;
          end
        end
        REQ: begin
          if (data_gnt_i) state <= RESP;
        end
        RESP: begin
          if (data_rvalid_i) begin
            if (!we_q) load_q <= fmt_data;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign data_req_o   = in_req;
  assign data_we_o    = in_req & we_q;
  assign data_be_o    = in_req ? be_q : '0;
  assign data_addr_o  = in_req ? {addr_q[31:2], 2'b00} : '0;
  assign data_wdata_o = in_req ? wdata_q : '0;

  assign lsu_data_o = (done && !we_q) ? fmt_data : load_q;

endmodule

// File: doc/miriscv_lsu.md
MIRISCV_LSU -- requirements
Module: miriscv_lsu

Interface
REQ-001 The module SHALL expose the following ports:
- clk_i  input  1  single clock, rising-edge.
- arstn_i  input  1  reset, asynchronous, active-low.
- lsu_req_i  input  1  memory instruction present; held by core while lsu_stall_req_o=1.
- lsu_we_i  input  1  1=store, 0=load.
- lsu_size_i  input  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- lsu_addr_i  input  32  byte address.
- lsu_data_i  input  32  store data, LSBs significant.
- lsu_data_o  output  32  load result, formatted.
- lsu_stall_req_o  output  1  core must hold PC and pipeline.
- lsu_err_o  output  1  misaligned or illegal-size access, 1-cycle pulse.
- data_req_o  output  1  memory request.
- data_we_o  output  1  memory write.
- data_be_o  output  4  byte enables.
- data_addr_o  output  32  word address, bits[1:0]=00.
- data_wdata_o  output  32  lane-replicated store data.
- data_gnt_i  input  1  request accepted.
- data_rvalid_i  input  1  response/ack; rdata valid for loads.
- data_rdata_i  input  32  read word.
REQ-002 The module SHALL have no parameters; all widths are fixed at 32-bit RV32.

Function
REQ-003 The module SHALL implement FSM states IDLE, REQ and RESP.
REQ-004 IDLE: on lsu_req_i=1 with a legal, aligned access, the module SHALL register addr/size/we/wdata and go to REQ; otherwise it SHALL stay in IDLE.
REQ-005 REQ: data_req_o SHALL be 1, driven from registered fields; on data_gnt_i=1 the FSM SHALL go to RESP, otherwise hold in REQ.
REQ-006 RESP: data_req_o SHALL be 0; on data_rvalid_i=1 the FSM SHALL go to IDLE, otherwise hold in RESP.
REQ-007 data_rvalid_i SHALL be ignored in IDLE and REQ.
REQ-008 lsu_stall_req_o SHALL be combinational, equal to lsu_req_i & ~(state==RESP & data_rvalid_i) & ~lsu_err_o.
- Minimum latency is 3 cycles: capture, req+gnt, rvalid.
REQ-009 Back-to-back accesses: lsu_req_i=1 in IDLE directly after completion SHALL start a new transaction; the completion cycle itself SHALL NOT recapture.
REQ-010 Misalignment SHALL be defined as: H/HU with addr[0]=1; W with addr[1:0]≠00. Illegal sizes are 011, 110, 111, and any store with size[2]=1.
REQ-011 On a misaligned or illegal request in IDLE, lsu_err_o SHALL be 1 that cycle, there SHALL be no memory access, and the stall SHALL NOT be asserted.
REQ-012 Byte enables SHALL be: B 0001<<addr[1:0]; H 0011<<addr[1:0]; W 1111.
REQ-013 Store data SHALL be: B {4{d[7:0]}}; H {2{d[15:0]}}; W d.
REQ-014 Load extraction SHALL select the byte or halfword at offset addr[1:0] of data_rdata_i; B/H SHALL sign-extend and BU/HU SHALL zero-extend.
REQ-015 lsu_data_o SHALL be the combinational formatted value in a load's RESP&rvalid cycle, and SHALL otherwise show a register holding the last load result.
REQ-016 data_we_o, data_be_o, data_addr_o and data_wdata_o SHALL be 0 outside REQ.

Reset
REQ-017 arstn_i=0 SHALL immediately force state IDLE and clear all registers, with lsu_data_o=0 and data_req_o=0.
REQ-018 Reset during REQ/RESP SHALL abandon the transaction, and a later stray rvalid SHALL be ignored per REQ-007.
REQ-019 The first request after release SHALL behave per REQ-004.

Structure
REQ-020 miriscv_pkg SHALL hold the LDST_B/H/W/BU/HU funct3 constants and the LSU state encoding.
REQ-021 Load extraction and sign extension SHALL be placed in a combinational sub-module, miriscv_lsu_ldfmt (rdata, offset, size -> data).
REQ-022 The RTL SHALL be 120-400 lines, and all state SHALL reside in miriscv_lsu.

Verification
REQ-023 LW addr 0x100, gnt same cycle as req, rvalid next cycle, rdata 0xDEADBEEF -> 3-cycle stall window, lsu_data_o=0xDEADBEEF, be=1111.
REQ-024 LB addr 0x103, rdata 0x80FF0011 -> lsu_data_o=0xFFFFFF80; LBU same address -> 0x00000080.
REQ-025 SH addr 0x202, data 0x1234ABCD, gnt delayed 3 cycles -> data_addr_o=0x200, be=1100, wdata=0xABCDABCD, stall held throughout.
REQ-026 LW addr 0x101 -> lsu_err_o pulse, data_req_o never 1, stall 0.
REQ-027 arstn_i low while in RESP, then rvalid pulse after release -> IDLE, no stall, lsu_data_o=0, rvalid ignored.
REQ-028 Two consecutive LWs (0x10, 0x14) -> second capture in the cycle after the first completes, both results correct.
